imem_boot_ctrl: RTL and testbench

//  Boot-load sequencer for the instruction RAM and the single-cycle core.

---
 rtl/imem_boot_ctrl_pkg.sv | 13 +
 rtl/imem_boot_ctrl_sync_edge.sv | 27 ++
 rtl/imem_boot_ctrl.sv | 146 ++++++++++++++
 tb/tb_imem_boot_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/imem_boot_ctrl_pkg.sv
// Types and default sizing for the instruction-RAM boot loader.
package boot_pkg;
  localparam int ADDR_W_DEF    = 7;
  localparam int DATA_W_DEF    = 32;
  localparam int MAX_WORDS_DEF = 128;
  localparam int BIT_CNT_W     = $clog2(DATA_W_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;
endpackage

// File: rtl/imem_boot_ctrl_sync_edge.sv
// Two-flop synchronizer for an asynchronous pad with one-cycle rise/fall pulses.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);
  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;
endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot-load sequencer: assembles serial words into instruction RAM and gates the core.
module imem_boot_ctrl
  import boot_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_WORDS = MAX_WORDS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic              sclk,
  input  logic              sdata,
  output logic              imem_sel,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              core_run,
  output logic [ADDR_W:0]   word_cnt,
  output logic              load_err
);
  localparam int BCW = $clog2(DATA_W);

  logic load_sync, load_rise, load_fall;
  logic sclk_rise, sclk_sync_unused, sclk_fall_unused;
  logic sdata_meta_q, sdata_sync_q;

  sync_edge u_load_sync (
    .clk(clk), .rst_n(rst_n), .async_i(load_en),
    .sync_o(load_sync), .rise_o(load_rise), .fall_o(load_fall)
  );

  sync_edge u_sclk_sync (
    .clk(clk), .rst_n(rst_n), .async_i(sclk),
    .sync_o(sclk_sync_unused), .rise_o(sclk_rise), .fall_o(sclk_fall_unused)
  );

  // sdata shares the sclk sync depth so it lines up with the detected edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sdata_meta_q <= 1'b0;
      sdata_sync_q <= 1'b0;
    end else begin
      sdata_meta_q <= sdata;
      sdata_sync_q <= sdata_meta_q;
    end
  end

  state_e            state_q, state_d;
  logic [1:0]        settle_q, settle_d;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // IDLE waits until the load_en synchronizer holds a real sample
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (settle_q == 2'd2) state_d = load_sync ? LOAD : RUN;
      LOAD:    if (load_fall) state_d = RUN;
      RUN:     if (load_rise) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    imem_sel = (state_q == LOAD);
    core_run = (state_q == RUN);
  end

  always_comb begin
    settle_d   = settle_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    word_cnt_d = word_cnt_q;
    err_d      = err_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if (state_q == IDLE && settle_q != 2'd2) settle_d = settle_q + 2'd1;
    if (state_q != LOAD && state_d == LOAD) begin
      bit_cnt_d  = '0;
      shift_d    = '0;
      word_cnt_d = '0;
      err_d      = 1'b0;
    end else if (state_q == LOAD) begin
      // a closing load_en beats a coincident sclk edge; that bit is lost
      if (load_fall) begin
        if (bit_cnt_q != '0) err_d = 1'b1;
        bit_cnt_d = '0;
      end else if (sclk_rise) begin
        shift_d[bit_cnt_q] = sdata_sync_q;
        if (bit_cnt_q == BCW'(DATA_W - 1)) begin
          bit_cnt_d = '0;
          if (word_cnt_q == (ADDR_W + 1)'(MAX_WORDS)) begin
            err_d = 1'b1;
          end else begin
            we_d       = 1'b1;
            addr_d     = word_cnt_q[ADDR_W-1:0];
            wdata_d    = shift_d;
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_q   <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      word_cnt_q <= '0;
      err_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      settle_q   <= settle_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      word_cnt_q <= word_cnt_d;
      err_q      <= err_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign word_cnt   = word_cnt_q;
  assign load_err   = err_q;
endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Scoreboard bench for imem_boot_ctrl: sessions of random words against a word-level model.
module tb_imem_boot_ctrl;
  localparam int ADDR_W    = 7;
  localparam int DATA_W    = 32;
  localparam int MAX_WORDS = 128;

  logic              clk = 1'b0;
  logic              rst_n, load_en, sclk, sdata;
  logic              imem_sel, imem_we, core_run, load_err;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic [ADDR_W:0]   word_cnt;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_chk = 0;
  int  n_err = 0;

  always #5 clk = ~clk;

  imem_boot_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .sclk(sclk), .sdata(sdata),
    .imem_sel(imem_sel), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .core_run(core_run), .word_cnt(word_cnt),
    .load_err(load_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (rst_n === 1'b1 && imem_we === 1'b1) begin
      chk("write_expected", 64'(exp_q.size() != 0), 64'd1);
      chk("write_sel", 64'(imem_sel), 64'd1);
      chk("write_core_stalled", 64'(core_run), 64'd0);
      if (exp_q.size() != 0) begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_addr", 64'(imem_addr), 64'(e.addr));
        chk("write_data", 64'(imem_wdata), 64'(e.data));
        $display("write addr=%0d data=0x%08h (expected addr=%0d data=0x%08h)",
                 imem_addr, imem_wdata, e.addr, e.data);
      end
    end
  end

  task automatic send_bits(input logic [DATA_W-1:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      sdata = w[i];
      repeat (3) @(negedge clk);
      sclk = 1'b1;
      repeat (3) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  // Model: complete word k lands at address k while k < MAX_WORDS;
  // error on any leftover bits or on words beyond capacity.
  task automatic session(input int n_words, input int part_bits,
                         input logic [DATA_W-1:0] first_word, input bit use_first);
    logic [DATA_W-1:0] w;
    int  exp_cnt;
    bit  exp_err;
    load_en = 1'b1;
    repeat (6) @(negedge clk);
    chk("sel_in_load", 64'(imem_sel), 64'd1);
    chk("run_low_in_load", 64'(core_run), 64'd0);
    for (int k = 0; k < n_words; k++) begin
      w = (k == 0 && use_first) ? first_word : DATA_W'($urandom);
      if (k < MAX_WORDS) exp_q.push_back('{addr: k[ADDR_W-1:0], data: w});
      send_bits(w, DATA_W);
    end
    if (part_bits > 0) send_bits(DATA_W'($urandom), part_bits);
    repeat (6) @(negedge clk);
    load_en = 1'b0;
    repeat (6) @(negedge clk);
    exp_cnt = (n_words > MAX_WORDS) ? MAX_WORDS : n_words;
    exp_err = (n_words > MAX_WORDS) || (part_bits != 0);
    chk("run_after_load", 64'(core_run), 64'd1);
    chk("sel_after_load", 64'(imem_sel), 64'd0);
    chk("word_cnt", 64'(word_cnt), 64'(exp_cnt));
    chk("load_err", 64'(load_err), 64'(exp_err));
    chk("writes_drained", 64'(exp_q.size()), 64'd0);
    $display("session words=%0d partial_bits=%0d -> word_cnt=%0d load_err=%0d",
             n_words, part_bits, word_cnt, load_err);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_sel"}, 64'(imem_sel), 64'd0);
    chk({tag, "_we"}, 64'(imem_we), 64'd0);
    chk({tag, "_addr"}, 64'(imem_addr), 64'd0);
    chk({tag, "_wdata"}, 64'(imem_wdata), 64'd0);
    chk({tag, "_run"}, 64'(core_run), 64'd0);
    chk({tag, "_word_cnt"}, 64'(word_cnt), 64'd0);
    chk({tag, "_err"}, 64'(load_err), 64'd0);
  endtask

  task automatic release_reset(input string tag);
    int cyc;
    rst_n = 1'b1;
    cyc = 0;
    while (core_run !== 1'b1 && cyc < 8) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_run_within_4"}, 64'(core_run === 1'b1 && cyc <= 4), 64'd1);
    $display("%s: core_run after %0d clk", tag, cyc);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw, pb;
    rst_n = 1'b0; load_en = 1'b0; sclk = 1'b0; sdata = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    release_reset("boot");
    repeat (10) @(negedge clk);

    session(1, 0, 32'h0050_0093, 1'b1);
    session(3, 0, '0, 1'b0);
    session(0, 20, '0, 1'b0);
    session(1, 0, '0, 1'b0);
    for (int r = 0; r < 3; r++) begin
      nw = int'($urandom_range(0, 4));
      pb = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 31)) : 0;
      session(nw, pb, '0, 1'b0);
    end
    session(MAX_WORDS + 1, 0, '0, 1'b0);

    // Reset in the middle of the second word: only word 1 may be written
    load_en = 1'b1;
    repeat (6) @(negedge clk);
    begin
      logic [DATA_W-1:0] w;
      w = DATA_W'($urandom);
      exp_q.push_back('{addr: '0, data: w});
      send_bits(w, DATA_W);
      send_bits(DATA_W'($urandom), 16);
    end
    chk("pre_reset_drained", 64'(exp_q.size()), 64'd0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midload_reset");
    load_en = 1'b0;
    repeat (4) @(negedge clk);
    release_reset("after_midload_reset");
    repeat (10) @(negedge clk);
    chk("midload_word_cnt", 64'(word_cnt), 64'd0);
    chk("midload_no_write", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
